// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO sequencer: op-bit positions, FSM encoding,
// operand-decode helper and HI/LO field positions within a 2*W result.
package muldiv_pkg;

    localparam int OP_W     = 6;
    localparam int OP_MULT  = 0;
    localparam int OP_MULTU = 1;
    localparam int OP_DIV   = 2;
    localparam int OP_DIVU  = 3;
    localparam int OP_MTHI  = 4;
    localparam int OP_MTLO  = 5;

    localparam int CNT_W = 4;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_MUL      = 3'd1;
    localparam logic [2:0] ST_DIV_REQ  = 3'd2;
    localparam logic [2:0] ST_DIV_WAIT = 3'd3;
    localparam logic [2:0] ST_DRAIN    = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE     = ST_IDLE,
        S_MUL      = ST_MUL,
        S_DIV_REQ  = ST_DIV_REQ,
        S_DIV_WAIT = ST_DIV_WAIT,
        S_DRAIN    = ST_DRAIN
    } state_t;

    // A result bus is {HI, LO}: HI occupies the upper half.
    function automatic int hi_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic logic op_is_onehot(input logic [OP_W-1:0] op);
        return (op != '0) && ((op & (op - OP_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/muldiv_ctrl_hilo_regs.sv
// Architectural HI/LO flops with a write mux for mthi, mtlo, multiplier and divider sources.
// Writes land at the clock edge they are enabled on; no backpressure.
module hilo_regs
    import muldiv_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_mthi_we,
    input  logic                i_mtlo_we,
    input  logic                i_mul_we,
    input  logic                i_div_we,
    input  logic [DATA_W-1:0]   i_mt_dat,
    input  logic [2*DATA_W-1:0] i_mul_dat,
    input  logic [2*DATA_W-1:0] i_div_dat,
    output logic [DATA_W-1:0]   o_hi,
    output logic [DATA_W-1:0]   o_lo
);

    localparam int HI_LSB = hi_lsb(DATA_W);

    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;
    logic [DATA_W-1:0] w_hi_nxt;
    logic [DATA_W-1:0] w_lo_nxt;

    always_comb begin
        w_hi_nxt = r_hi;
        w_lo_nxt = r_lo;
        if (i_mul_we) begin
            w_hi_nxt = i_mul_dat[HI_LSB +: DATA_W];
            w_lo_nxt = i_mul_dat[0 +: DATA_W];
        end else if (i_div_we) begin
            w_hi_nxt = i_div_dat[HI_LSB +: DATA_W];
            w_lo_nxt = i_div_dat[0 +: DATA_W];
        end else begin
            if (i_mthi_we) w_hi_nxt = i_mt_dat;
            if (i_mtlo_we) w_lo_nxt = i_mt_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else begin
            r_hi <= w_hi_nxt;
            r_lo <= w_lo_nxt;
        end
    end

    assign o_hi = r_hi;
    assign o_lo = r_lo;

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO sequencer: one mult/div/mthi/mtlo in flight; done pulses the cycle HI/LO show the result
// (mt*: T+1, mult: T+MUL_LAT+1, div: cycle after div_out_valid); req_ready only in IDLE without flush.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int MUL_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [OP_W-1:0]     req_op,
    input  logic [DATA_W-1:0]   req_src1,
    input  logic [DATA_W-1:0]   req_src2,
    output logic                done,
    output logic                busy,
    output logic [DATA_W-1:0]   hi,
    output logic [DATA_W-1:0]   lo,
    output logic [1:0]          mul_op,
    output logic [DATA_W-1:0]   mul_src1,
    output logic [DATA_W-1:0]   mul_src2,
    input  logic [2*DATA_W-1:0] mul_result,
    output logic [1:0]          div_op,
    output logic [DATA_W-1:0]   div_dividend,
    output logic [DATA_W-1:0]   div_divisor,
    output logic                div_in_valid,
    input  logic                div_in_ready,
    input  logic [2*DATA_W-1:0] div_result,
    input  logic                div_out_valid,
    output logic                div_out_ready
);

    localparam logic [CNT_W-1:0] LP_MUL_LAT = CNT_W'(MUL_LAT);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [3:0]         r_op;
    logic [DATA_W-1:0]  r_src1;
    logic [DATA_W-1:0]  r_src2;
    logic               r_done;
    logic               w_done_nxt;
    logic               w_accept;
    logic               w_mthi_we;
    logic               w_mtlo_we;
    logic               w_mul_we;
    logic               w_div_we;

    assign req_ready = (r_state == S_IDLE) && !flush;
    assign w_accept  = req_valid && req_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        w_mthi_we   = 1'b0;
        w_mtlo_we   = 1'b0;
        w_mul_we    = 1'b0;
        w_div_we    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    // A malformed op is swallowed as a NOP so the pipeline still sees done.
                    if (!op_is_onehot(req_op)) begin
                        w_done_nxt = 1'b1;
                    end else if (req_op[OP_MTHI]) begin
                        w_mthi_we  = 1'b1;
                        w_done_nxt = 1'b1;
                    end else if (req_op[OP_MTLO]) begin
                        w_mtlo_we  = 1'b1;
                        w_done_nxt = 1'b1;
                    end else if (req_op[OP_MULT] || req_op[OP_MULTU]) begin
                        w_state_nxt = S_MUL;
                        w_cnt_nxt   = LP_MUL_LAT;
                    end else begin
                        w_state_nxt = S_DIV_REQ;
                    end
                end
            end
            S_MUL: begin
                if (flush) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_W'(1)) begin
                    w_mul_we    = 1'b1;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_DIV_REQ: begin
                // Once the divider has taken operands its result must still be consumed.
                if (flush) begin
                    w_state_nxt = div_in_ready ? S_DRAIN : S_IDLE;
                end else if (div_in_ready) begin
                    w_state_nxt = S_DIV_WAIT;
                end
            end
            S_DIV_WAIT: begin
                if (flush) begin
                    w_state_nxt = div_out_valid ? S_IDLE : S_DRAIN;
                end else if (div_out_valid) begin
                    w_div_we    = 1'b1;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (div_out_valid) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_op    <= '0;
            r_src1  <= '0;
            r_src2  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
            if (w_accept) begin
                r_op   <= req_op[OP_DIVU:OP_MULT];
                r_src1 <= req_src1;
                r_src2 <= req_src2;
            end
        end
    end

    hilo_regs #(
        .DATA_W (DATA_W)
    ) u_hilo (
        .clk       (clk),
        .rst       (rst),
        .i_mthi_we (w_mthi_we),
        .i_mtlo_we (w_mtlo_we),
        .i_mul_we  (w_mul_we),
        .i_div_we  (w_div_we),
        .i_mt_dat  (req_src1),
        .i_mul_dat (mul_result),
        .i_div_dat (div_result),
        .o_hi      (hi),
        .o_lo      (lo)
    );

    assign done          = r_done;
    assign busy          = (r_state != S_IDLE);
    assign div_in_valid  = (r_state == S_DIV_REQ);
    assign div_out_ready = (r_state == S_DIV_WAIT) || (r_state == S_DRAIN);
    assign mul_op        = (r_state == S_MUL) ? {r_op[OP_MULTU], r_op[OP_MULT]} : 2'b00;
    assign div_op        = ((r_state == S_DIV_REQ) || (r_state == S_DIV_WAIT)) ?
                           {r_op[OP_DIVU], r_op[OP_DIV]} : 2'b00;
    assign mul_src1      = r_src1;
    assign mul_src2      = r_src2;
    assign div_dividend  = r_src1;
    assign div_divisor   = r_src2;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: behavioural multiplier/divider, vector table and scoreboard-checked completions.
module tb_muldiv_ctrl;

    localparam int DW = 32;
    localparam int ML = 1;

    localparam logic [5:0] T_MULT  = 6'b000001;
    localparam logic [5:0] T_MULTU = 6'b000010;
    localparam logic [5:0] T_DIV   = 6'b000100;
    localparam logic [5:0] T_DIVU  = 6'b001000;
    localparam logic [5:0] T_MTHI  = 6'b010000;
    localparam logic [5:0] T_MTLO  = 6'b100000;
    localparam int LAT_DIV = -2;

    logic          clk, rst, flush, req_valid, req_ready, done, busy;
    logic [5:0]    req_op;
    logic [DW-1:0] req_src1, req_src2, hi, lo, mul_src1, mul_src2, div_dividend, div_divisor;
    logic [1:0]    mul_op, div_op;
    logic [2*DW-1:0] mul_result, div_result;
    logic          div_in_valid, div_in_ready, div_out_valid, div_out_ready;

    muldiv_ctrl #(.DATA_W(DW), .MUL_LAT(ML)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_src1(req_src1), .req_src2(req_src2),
        .done(done), .busy(busy), .hi(hi), .lo(lo),
        .mul_op(mul_op), .mul_src1(mul_src1), .mul_src2(mul_src2), .mul_result(mul_result),
        .div_op(div_op), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_in_valid(div_in_valid), .div_in_ready(div_in_ready),
        .div_result(div_result), .div_out_valid(div_out_valid), .div_out_ready(div_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational multiplier: sign- or zero-extend, keep the low 64 bits of the product.
    logic [63:0] w_ma, w_mb;
    assign w_ma = mul_op[0] ? {{32{mul_src1[31]}}, mul_src1} : {32'b0, mul_src1};
    assign w_mb = mul_op[0] ? {{32{mul_src2[31]}}, mul_src2} : {32'b0, mul_src2};
    assign mul_result = w_ma * w_mb;

    function automatic logic [63:0] div_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (op[0]) begin
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int cfg_in_dly = 1;
    int cfg_out_dly = 2;

    typedef struct { logic [31:0] hi; logic [31:0] lo; int lat; int t; } exp_t;
    exp_t sb_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) cyc <= cyc + 1;

    // Handshaked divider: ready after cfg_in_dly cycles of valid, result cfg_out_dly cycles later.
    initial begin : divider_model
        logic l_in_hs, l_out_hs, computing;
        int in_cnt, out_cnt;
        logic [1:0] c_op;
        logic [31:0] c_a, c_b;
        logic [63:0] res;
        l_in_hs = 0; l_out_hs = 0; computing = 0; in_cnt = 0; out_cnt = 0;
        c_op = '0; c_a = '0; c_b = '0; res = '0;
        div_in_ready = 0; div_out_valid = 0; div_result = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                l_in_hs = 0; l_out_hs = 0; computing = 0; in_cnt = 0; out_cnt = 0;
                div_in_ready = 0; div_out_valid = 0;
            end else begin
                if (l_in_hs) begin
                    res = div_model(c_op, c_a, c_b);
                    out_cnt = cfg_out_dly;
                    computing = 1;
                end
                if (l_out_hs) div_out_valid = 0;
                div_in_ready = 0;
                if (div_in_valid && !computing && !div_out_valid) begin
                    if (in_cnt >= cfg_in_dly) div_in_ready = 1;
                    else in_cnt++;
                end else begin
                    in_cnt = 0;
                end
                if (computing) begin
                    if (out_cnt <= 1) begin
                        div_out_valid = 1; div_result = res; computing = 0;
                    end else begin
                        out_cnt--;
                    end
                end
                l_in_hs = div_in_valid && div_in_ready;
                if (l_in_hs) begin
                    c_op = div_op; c_a = div_dividend; c_b = div_divisor; in_cnt = 0;
                end
                l_out_hs = div_out_valid && div_out_ready;
            end
        end
    end

    // Completion monitor: every done pops one expectation.
    initial begin : monitor
        logic prev_ohs;
        exp_t e;
        prev_ohs = 0;
        forever begin
            @(negedge clk); #2;
            if (done) begin
                if (sb_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL spurious_done: done=1 with nothing outstanding (cycle %0d)", cyc);
                end else begin
                    e = sb_q.pop_front();
                    chk("done_hi", 64'(hi), 64'(e.hi));
                    chk("done_lo", 64'(lo), 64'(e.lo));
                    if (e.lat == LAT_DIV) chk("div_done_after_out_valid", 64'(prev_ohs), 64'(1));
                    else chk("done_latency", 64'(cyc - e.t), 64'(e.lat));
                end
            end
            prev_ohs = div_out_valid && div_out_ready;
        end
    end

    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic push, input logic [31:0] ehi, input logic [31:0] elo, input int lat);
        int n;
        exp_t e;
        @(negedge clk);
        req_valid = 1; req_op = op; req_src1 = a; req_src2 = b;
        #1;
        n = 0;
        while (!req_ready && n < 60) begin
            @(negedge clk); #1; n++;
        end
        if (!req_ready) begin
            checks++; failures++;
            $display("FAIL issue_timeout: req_ready=0 after %0d cycles, required 1", n);
        end else if (push) begin
            e.hi = ehi; e.lo = elo; e.lat = lat; e.t = cyc;
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
        req_valid = 0; req_op = '0;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while ((busy || sb_q.size() != 0) && n < limit) begin
            @(negedge clk); #3; n++;
        end
        if (busy || sb_q.size() != 0) begin
            checks++; failures++;
            $display("FAIL idle_timeout: busy=%0d outstanding=%0d required 0/0", busy, sb_q.size());
        end
    endtask

    task automatic wait_div_wait(input int limit);
        int n;
        n = 0;
        while (!(busy && div_out_ready) && n < limit) begin
            @(posedge clk); #1; n++;
        end
        chk("reach_div_wait", 64'(busy && div_out_ready), 64'(1));
    endtask

    typedef struct { logic [5:0] op; logic [31:0] a; logic [31:0] b; logic [31:0] hi; logic [31:0] lo; int lat; } vec_t;

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t tbl[13];
        int held, bad;
        logic [31:0] s_hi, s_lo;

        tbl[0]  = '{T_MTHI,   32'h1234_5678, 32'h0,         32'h1234_5678, 32'h0000_0000, 1};
        tbl[1]  = '{T_MTLO,   32'hDEAD_BEEF, 32'h0,         32'h1234_5678, 32'hDEAD_BEEF, 1};
        tbl[2]  = '{T_MULT,   32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, ML + 1};
        tbl[3]  = '{T_MULTU,  32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA, ML + 1};
        tbl[4]  = '{T_DIV,    32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, LAT_DIV};
        tbl[5]  = '{T_DIVU,   32'hFFFF_FFF0, 32'h0000_0010, 32'h0000_0000, 32'h0FFF_FFFF, LAT_DIV};
        tbl[6]  = '{T_DIV,    32'h8000_0000, 32'h0000_0003, 32'hFFFF_FFFE, 32'hD555_5556, LAT_DIV};
        tbl[7]  = '{6'b000011, 32'h1111_1111, 32'h2,        32'hFFFF_FFFE, 32'hD555_5556, 1};
        tbl[8]  = '{6'b000000, 32'h3333_3333, 32'h4,        32'hFFFF_FFFE, 32'hD555_5556, 1};
        tbl[9]  = '{T_MULT,   32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, ML + 1};
        tbl[10] = '{T_MTLO,   32'hCAFE_F00D, 32'h0,         32'h0000_0001, 32'hCAFE_F00D, 1};
        tbl[11] = '{6'b110000, 32'h5555_5555, 32'h0,        32'h0000_0001, 32'hCAFE_F00D, 1};
        tbl[12] = '{T_DIVU,   32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, LAT_DIV};

        rst = 1; flush = 0; req_valid = 0; req_op = '0; req_src1 = '0; req_src2 = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_hi", 64'(hi), 64'(0));
        chk("rst_lo", 64'(lo), 64'(0));
        chk("rst_busy_done", 64'({busy, done}), 64'(0));
        chk("rst_div_in_valid", 64'(div_in_valid), 64'(0));
        chk("rst_req_ready", 64'(req_ready), 64'(1));
        chk("rst_ops", 64'({mul_op, div_op}), 64'(0));
        chk("rst_operands", 64'({div_dividend, div_divisor}), 64'(0));
        @(negedge clk); #3; rst = 0;

        for (int i = 0; i < 13; i++)
            issue(tbl[i].op, tbl[i].a, tbl[i].b, 1'b1, tbl[i].hi, tbl[i].lo, tbl[i].lat);
        wait_idle(200);

        // Signed divide with a slow divider: operands must sit still until taken.
        cfg_in_dly = 3; cfg_out_dly = 10;
        issue(T_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, LAT_DIV);
        held = 0; bad = 0;
        while (div_in_valid && held < 30) begin
            held++;
            if (div_dividend !== 32'hFFFF_FFF9 || div_divisor !== 32'd2 || div_op !== 2'b01) bad++;
            @(posedge clk); #1;
        end
        chk("div_in_valid_cycles", 64'(held), 64'(4));
        chk("div_operands_stable", 64'(bad), 64'(0));
        wait_idle(100);

        // Flush in DIV_WAIT: result drained silently, HI/LO untouched.
        cfg_in_dly = 0; cfg_out_dly = 5;
        s_hi = hi; s_lo = lo;
        issue(T_DIVU, 32'd50, 32'd5, 1'b0, 32'h0, 32'h0, 0);
        wait_div_wait(20);
        @(negedge clk); flush = 1;
        @(posedge clk); #1;
        chk("drain_state", 64'({busy, div_out_ready, div_in_valid}), 64'(3'b110));
        @(negedge clk); flush = 0;
        wait_idle(50);
        chk("drain_hi_kept", 64'(hi), 64'(s_hi));
        chk("drain_lo_kept", 64'(lo), 64'(s_lo));

        // Flush coinciding with div_out_valid: result dropped, straight to IDLE.
        cfg_out_dly = 1;
        issue(T_DIVU, 32'd77, 32'd7, 1'b0, 32'h0, 32'h0, 0);
        wait_div_wait(20);
        @(negedge clk); flush = 1;
        #1; chk("flush_with_out_valid", 64'(div_out_valid), 64'(1));
        @(posedge clk); #1;
        chk("flush_out_valid_idle", 64'(busy), 64'(0));
        @(negedge clk); flush = 0;
        chk("flush_out_valid_hi_lo", 64'({hi, lo}), 64'({s_hi, s_lo}));

        cfg_out_dly = 2;
        issue(T_MULT, 32'h0001_0001, 32'h0003_0000, 1'b1, 32'h0000_0003, 32'h0003_0000, ML + 1);
        wait_idle(50);

        // Request during flush is refused; flush during MUL drops the product.
        @(negedge clk);
        flush = 1; req_valid = 1; req_op = T_MULT; req_src1 = 32'd3; req_src2 = 32'd4;
        #1; chk("flush_req_ready", 64'(req_ready), 64'(0));
        @(posedge clk); #1;
        chk("flush_req_no_accept", 64'(busy), 64'(0));
        req_valid = 0; req_op = '0; flush = 0;
        issue(T_MULT, 32'd3, 32'd4, 1'b0, 32'h0, 32'h0, 0);
        chk("mul_busy", 64'({busy, mul_op}), 64'(3'b101));
        @(negedge clk); flush = 1;
        @(posedge clk); #1; flush = 0;
        chk("mul_flush_idle", 64'(busy), 64'(0));
        repeat (2) @(negedge clk);
        chk("mul_flush_no_write", 64'({hi, lo}), 64'({32'h0000_0003, 32'h0003_0000}));

        // Flush in DIV_REQ before the divider takes operands.
        cfg_in_dly = 5;
        issue(T_DIV, 32'd9, 32'd3, 1'b0, 32'h0, 32'h0, 0);
        chk("div_req_valid", 64'(div_in_valid), 64'(1));
        @(negedge clk); flush = 1;
        @(posedge clk); #1; flush = 0;
        chk("div_req_flush", 64'({busy, div_in_valid}), 64'(0));

        // Async reset in DIV_WAIT clears state without a clock edge.
        cfg_in_dly = 0; cfg_out_dly = 30;
        issue(T_DIVU, 32'h99, 32'd3, 1'b0, 32'h0, 32'h0, 0);
        wait_div_wait(20);
        @(negedge clk); #2; rst = 1; #1;
        chk("arst_hi", 64'(hi), 64'(0));
        chk("arst_lo", 64'(lo), 64'(0));
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_div_in_valid", 64'({div_in_valid, div_out_ready}), 64'(0));
        repeat (2) @(negedge clk);
        #3; rst = 0;

        issue(T_MTHI, 32'h0BAD_F00D, 32'h0, 1'b1, 32'h0BAD_F00D, 32'h0, 1);
        wait_idle(20);
        chk("end_ops_idle", 64'({mul_op, div_op}), 64'(0));
        chk("end_scoreboard_empty", 64'(sb_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
